// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N up/down counter with load, range check and cascade carry.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset (count <= RESET_VAL, load_err <= 0)
//   enable    in   1      one count step per cycle while high
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load, beats enable
//   load_val  in   WIDTH  value to load; >= MODULUS saturates to MODULUS-1 and flags load_err
//   count     out  WIDTH  registered count, always in 0..MODULUS-1
//   carry     out  1      combinational wrap flag (carry up / borrow down) for the next stage's enable
//   load_err  out  1      registered one-cycle pulse after an out-of-range load
//
// Optional feature, macro ALARM_MATCH_EN, adds:
//   alarm_val in   WIDTH  alarm compare value
//   alarm_set in   1      captures alarm_val into the alarm register (reset value 0)
//   alarm_hit out  1      registered pulse the cycle after an enable step lands on the alarm value
module mod_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef ALARM_MATCH_EN
    input  logic [WIDTH-1:0] alarm_val,
    input  logic             alarm_set,
    output logic             alarm_hit,
`endif
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2^WIDTH is representable in the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;
    logic [WIDTH-1:0] count_nxt;

    // Wrap is by explicit compare so a non-power-of-2 modulus is exact.
    always_comb begin
        at_max    = count == MAX_VAL;
        at_zero   = count == '0;
        step_up   = at_max ? '0 : count + 1'b1;
        step_dn   = at_zero ? MAX_VAL : count - 1'b1;
        load_ok   = {1'b0, load_val} < MOD_EXT;
        count_nxt = load   ? (load_ok ? load_val : MAX_VAL) :
                    enable ? (up_dn ? step_up : step_dn) : count;
    end

    // Combinational so the next stage steps on the same edge this one wraps.
    assign carry = enable & ~load & (up_dn ? at_max : at_zero);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= RST_VAL;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            load_err <= load & ~load_ok;
        end
    end

`ifdef ALARM_MATCH_EN
    logic [WIDTH-1:0] alarm_reg;
    logic             stepped;

    // stepped marks that the last edge was an enable step, so loads, reset
    // and holds never produce a match; an out-of-range alarm can never equal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_reg <= '0;
            stepped   <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (alarm_set) alarm_reg <= alarm_val;
            stepped   <= enable & ~load;
            alarm_hit <= stepped & (count == alarm_reg);
        end
    end
`endif
endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, enable = 1'b0, up_dn = 1'b1, load = 1'b0, min_load = 1'b0;
    logic [5:0] load_val = '0, min_val = '0, count, min_count;
    logic       carry, load_err, min_carry, min_err, p_carry, p_err;
    logic [1:0] p_count;
`ifdef ALARM_MATCH_EN
    logic [5:0] alarm_val = '0;
    logic       alarm_set = 1'b0, alarm_hit, min_hit, p_hit;
    int         m_alarm = 0;
    bit         m_stepped = 0, m_hit = 0;
`endif

    int checks = 0, failures = 0;
    int m_sec = 0, m_min = 0, m_p = 1;
    bit m_err = 0, m_min_err = 0, m_valid = 0;

    mod_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef ALARM_MATCH_EN
        .alarm_val(alarm_val), .alarm_set(alarm_set), .alarm_hit(alarm_hit),
`endif
        .count(count), .carry(carry), .load_err(load_err));

    mod_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) u_min (
        .clk(clk), .rst_n(rst_n), .enable(carry), .up_dn(up_dn), .load(min_load), .load_val(min_val),
`ifdef ALARM_MATCH_EN
        .alarm_val(6'd0), .alarm_set(1'b0), .alarm_hit(min_hit),
`endif
        .count(min_count), .carry(min_carry), .load_err(min_err));

    mod_counter #(.MODULUS(4), .WIDTH(2), .RESET_VAL(1)) u_p (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load), .load_val(load_val[1:0]),
`ifdef ALARM_MATCH_EN
        .alarm_val(2'd0), .alarm_set(1'b0), .alarm_hit(p_hit),
`endif
        .count(p_count), .carry(p_carry), .load_err(p_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks carry before the edge, advances the reference model at the edge, then checks state.
    task automatic tick();
        int  d, lv, mv;
        bit  ec, epc;
        #1;
        d   = up_dn ? 1 : -1;
        lv  = int'(load_val);
        mv  = int'(min_val);
        ec  = enable && !load && (m_sec + d < 0 || m_sec + d > 59);
        epc = enable && !load && (m_p + d < 0 || m_p + d > 3);
        if (m_valid) begin
            chk("carry", 32'(carry), 32'(ec));
            chk("p_carry", 32'(p_carry), 32'(epc));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_sec = 0; m_min = 0; m_p = 1; m_err = 0; m_min_err = 0; m_valid = 1;
`ifdef ALARM_MATCH_EN
            m_alarm = 0; m_stepped = 0; m_hit = 0;
`endif
        end else begin
`ifdef ALARM_MATCH_EN
            m_hit = m_stepped && m_sec == m_alarm;
            m_stepped = enable && !load;
            if (alarm_set) m_alarm = int'(alarm_val);
`endif
            m_err     = load && lv >= 60;
            m_min_err = min_load && mv >= 60;
            if (min_load) m_min = mv < 60 ? mv : 59;
            else if (ec) m_min = (m_min + d + 60) % 60;
            m_sec = load ? (lv < 60 ? lv : 59) : enable ? (m_sec + d + 60) % 60 : m_sec;
            m_p   = load ? lv % 4 : enable ? (m_p + d + 4) % 4 : m_p;
        end
        #1;
        chk("count", 32'(count), 32'(m_sec));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("min_count", 32'(min_count), 32'(m_min));
        chk("min_err", 32'(min_err), 32'(m_min_err));
        chk("p_count", 32'(p_count), 32'(m_p));
        chk("p_err", 32'(p_err), 32'd0);
`ifdef ALARM_MATCH_EN
        chk("alarm_hit", 32'(alarm_hit), 32'(m_hit));
`endif
    endtask

    initial begin
        // Reset
        rst_n = 0; tick();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_p_count", 32'(p_count), 32'd1);
        rst_n = 1;
        // 1: up-count through the wrap, and no carry while disabled at 59
        enable = 1; up_dn = 1;
        repeat (59) tick();
        chk("t1_at59", 32'(count), 32'd59);
        enable = 0; tick();
        chk("t1_hold59", 32'(count), 32'd59);
        enable = 1; tick();
        chk("t1_wrap", 32'(count), 32'd0);
        chk("t1_min_step", 32'(min_count), 32'd1);
        // 2: load 5 then down-count through the borrow
        load = 1; load_val = 6'd5; tick();
        load = 0; up_dn = 0;
        repeat (7) tick();
        chk("t2_borrow", 32'(count), 32'd58);
        // 3: out-of-range load saturates and flags for exactly one cycle
        load = 1; load_val = 6'd63; enable = 0; tick();
        chk("t3_sat", 32'(count), 32'd59);
        chk("t3_err", 32'(load_err), 32'd1);
        load = 0; tick();
        chk("t3_err_clr", 32'(load_err), 32'd0);
        load = 1; load_val = 6'd60; tick();
        chk("t3_err60", 32'(load_err), 32'd1);
        // load with enable at the boundary suppresses carry
        up_dn = 1; enable = 1; load_val = 6'd12; tick();
        chk("t3_load_beats_en", 32'(count), 32'd12);
        // 4: reset mid-count at 59
        load_val = 6'd59; tick();
        load = 0; rst_n = 0; tick();
        chk("t4_rst", 32'(count), 32'd0);
        rst_n = 1; enable = 0; tick();
        // cascade sec=59, min=59 wraps both on the same edge
        load = 1; load_val = 6'd59; min_load = 1; min_val = 6'd59; tick();
        load = 0; min_load = 0; enable = 1; tick();
        chk("t4_sec_wrap", 32'(count), 32'd0);
        chk("t4_min_wrap", 32'(min_count), 32'd0);
        // boundary: power-of-2 modulus wraps like natural overflow
        up_dn = 0; repeat (3) tick();
        up_dn = 1; repeat (5) tick();
`ifdef ALARM_MATCH_EN
        // 5: alarm at 10, reached by stepping, then by loading
        enable = 0; load = 1; load_val = 6'd7; tick();
        load = 0; enable = 1; alarm_set = 1; alarm_val = 6'd10; tick();
        alarm_set = 0; tick(); tick();
        chk("t5_no_hit_yet", 32'(alarm_hit), 32'd0);
        tick();
        chk("t5_hit", 32'(alarm_hit), 32'd1);
        tick();
        chk("t5_hit_once", 32'(alarm_hit), 32'd0);
        enable = 0; load = 1; load_val = 6'd10; tick();
        load = 0; tick(); tick();
        chk("t5_load_no_hit", 32'(alarm_hit), 32'd0);
`endif
        // Randomised traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            rst_n    = $urandom_range(0, 49) != 0;
            enable   = $urandom_range(0, 3) != 0;
            up_dn    = $urandom_range(0, 1) != 0;
            load     = $urandom_range(0, 9) == 0;
            load_val = 6'($urandom);
            min_load = $urandom_range(0, 19) == 0;
            min_val  = 6'($urandom);
`ifdef ALARM_MATCH_EN
            alarm_set = $urandom_range(0, 15) == 0;
            alarm_val = 6'($urandom);
`endif
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
